// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr
// ---------------
// Two-master round-robin bus arbiter with a serial slave address phase,
// slave-ready wait, a transfer phase and a forced one-cycle release.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   m1_request     master1 bus request (level, held for the whole transaction)
//   m2_request     master2 bus request (level, held for the whole transaction)
//   m1_slave_sel   master1 serial slave address, LSB first, 2 bits
//   m2_slave_sel   master2 serial slave address, LSB first, 2 bits
//   slave_ready    addressed slave can accept a transfer
//   trans_done     single-cycle end-of-transfer pulse from the granted master
//   m1_grant       master1 grant
//   m2_grant       master2 grant
//   bus_grant      owner code: 0 none, 1 master1, 2 master2
//   slave_sel      decoded slave index
//   sel_valid      slave_sel stable and transfer enabled
//   arbiter_busy   high in every state except IDLE
//   addr_err       one-cycle pulse when address 2'b11 is received
//   timeout_err    one-cycle pulse on a timeout release
//   state_dbg      current FSM state (debug visibility)
//
// Request/grant handshake: a master raises its request (level) and keeps it
// high for the whole transaction. The grant appears one edge after the
// request is seen in IDLE and stays constant until the arbiter enters
// RELEASE. Dropping the request while owning the bus ends the transaction
// (release with no error). A request that is not granted is ignored until
// the arbiter is back in IDLE; there is no preemption.

module bus_arbiter_rr #(
   parameter logic [7:0] TIMEOUT = 8'd200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       m1_request,
   input  logic       m2_request,
   input  logic       m1_slave_sel,
   input  logic       m2_slave_sel,
   input  logic       slave_ready,
   input  logic       trans_done,
   output logic       m1_grant,
   output logic       m2_grant,
   output logic [1:0] bus_grant,
   output logic [1:0] slave_sel,
   output logic       sel_valid,
   output logic       arbiter_busy,
   output logic       addr_err,
   output logic       timeout_err,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ADDR0      = 3'd1,
      ADDR1      = 3'd2,
      SLAVE_WAIT = 3'd3,
      XFER       = 3'd4,
      RELEASE    = 3'd5
   } state_t;

   state_t     state, state_n;
   logic [7:0] wait_cnt, wait_cnt_n;
   logic       last_m2, last_m2_n;   // 1: master2 was served last

   logic       m1_grant_n, m2_grant_n;
   logic [1:0] bus_grant_n, slave_sel_n;
   logic       sel_valid_n, arbiter_busy_n, addr_err_n, timeout_err_n;

   logic       own_req, own_ser, timeout_hit, rel;

   // Request and serial bit of whichever master currently owns the bus.
   assign own_req     = m1_grant ? m1_request   : m2_request;
   assign own_ser     = m1_grant ? m1_slave_sel : m2_slave_sel;
   assign timeout_hit = (wait_cnt == (TIMEOUT - 8'd1));
   assign state_dbg   = state;

   always_comb begin
      state_n       = state;
      wait_cnt_n    = wait_cnt;
      last_m2_n     = last_m2;
      m1_grant_n    = m1_grant;
      m2_grant_n    = m2_grant;
      bus_grant_n   = bus_grant;
      slave_sel_n   = slave_sel;
      sel_valid_n   = sel_valid;
      addr_err_n    = 1'b0;
      timeout_err_n = 1'b0;
      rel           = 1'b0;

      case (state)
         IDLE: begin
            // master1 wins when alone or when master2 was served last.
            if (m1_request && (!m2_request || last_m2)) begin
               m1_grant_n  = 1'b1;
               bus_grant_n = 2'd1;
               last_m2_n   = 1'b0;
               state_n     = ADDR0;
            end else if (m2_request) begin
               m2_grant_n  = 1'b1;
               bus_grant_n = 2'd2;
               last_m2_n   = 1'b1;
               state_n     = ADDR0;
            end
         end
         ADDR0: begin
            if (!own_req) begin
               rel = 1'b1;
            end else begin
               slave_sel_n[0] = own_ser;
               state_n        = ADDR1;
            end
         end
         ADDR1: begin
            if (!own_req) begin
               rel = 1'b1;
            end else if (own_ser && slave_sel[0]) begin
               rel        = 1'b1;
               addr_err_n = 1'b1;
            end else begin
               slave_sel_n[1] = own_ser;
               wait_cnt_n     = 8'd0;
               state_n        = SLAVE_WAIT;
            end
         end
         SLAVE_WAIT: begin
            if (!own_req) begin
               rel = 1'b1;
            end else if (slave_ready) begin
               sel_valid_n = 1'b1;
               wait_cnt_n  = 8'd0;
               state_n     = XFER;
            end else if (timeout_hit) begin
               rel           = 1'b1;
               timeout_err_n = 1'b1;
            end else begin
               wait_cnt_n = wait_cnt + 8'd1;
            end
         end
         XFER: begin
            // trans_done is checked first so it wins over a same-edge timeout.
            if (trans_done || !own_req) begin
               rel = 1'b1;
            end else if (timeout_hit) begin
               rel           = 1'b1;
               timeout_err_n = 1'b1;
            end else begin
               wait_cnt_n = wait_cnt + 8'd1;
            end
         end
         RELEASE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // Entering RELEASE drops ownership so the bus is idle for that cycle.
      if (rel) begin
         state_n     = RELEASE;
         m1_grant_n  = 1'b0;
         m2_grant_n  = 1'b0;
         bus_grant_n = 2'd0;
         slave_sel_n = 2'd0;
         sel_valid_n = 1'b0;
         wait_cnt_n  = 8'd0;
      end

      arbiter_busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         wait_cnt     <= 8'd0;
         last_m2      <= 1'b1;
         m1_grant     <= 1'b0;
         m2_grant     <= 1'b0;
         bus_grant    <= 2'd0;
         slave_sel    <= 2'd0;
         sel_valid    <= 1'b0;
         arbiter_busy <= 1'b0;
         addr_err     <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         state        <= state_n;
         wait_cnt     <= wait_cnt_n;
         last_m2      <= last_m2_n;
         m1_grant     <= m1_grant_n;
         m2_grant     <= m2_grant_n;
         bus_grant    <= bus_grant_n;
         slave_sel    <= slave_sel_n;
         sel_valid    <= sel_valid_n;
         arbiter_busy <= arbiter_busy_n;
         addr_err     <= addr_err_n;
         timeout_err  <= timeout_err_n;
      end
   end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr
// -----------------
// Self-checking bench for bus_arbiter_rr (TIMEOUT = 4). Each scenario task
// holds a per-cycle stimulus table {m1_req, m2_req, m1_ser, m2_ser,
// slave_ready, trans_done} and the expected registered outputs
// {m1_grant, m2_grant, bus_grant, slave_sel, sel_valid, arbiter_busy,
// addr_err, timeout_err}, pushed into exp_q as the stimulus is driven and
// popped after the clock edge.

module tb_bus_arbiter_rr;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       m1_request = 1'b0, m2_request = 1'b0;
   logic       m1_slave_sel = 1'b0, m2_slave_sel = 1'b0;
   logic       slave_ready = 1'b0, trans_done = 1'b0;
   logic       m1_grant, m2_grant, sel_valid, arbiter_busy, addr_err, timeout_err;
   logic [1:0] bus_grant, slave_sel;
   logic [2:0] state_dbg;

   int checks = 0;
   int errors = 0;
   logic [9:0] exp_q[$];

   bus_arbiter_rr #(.TIMEOUT(8'd4)) dut (
      .clk(clk), .rst(rst),
      .m1_request(m1_request), .m2_request(m2_request),
      .m1_slave_sel(m1_slave_sel), .m2_slave_sel(m2_slave_sel),
      .slave_ready(slave_ready), .trans_done(trans_done),
      .m1_grant(m1_grant), .m2_grant(m2_grant), .bus_grant(bus_grant),
      .slave_sel(slave_sel), .sel_valid(sel_valid), .arbiter_busy(arbiter_busy),
      .addr_err(addr_err), .timeout_err(timeout_err), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   function automatic logic [9:0] outs();
      return {m1_grant, m2_grant, bus_grant, slave_sel, sel_valid,
              arbiter_busy, addr_err, timeout_err};
   endfunction

   // driver tasks
   task automatic drive(input logic [5:0] s);
      {m1_request, m2_request, m1_slave_sel, m2_slave_sel, slave_ready, trans_done} = s;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [9:0] got;
      drive(6'b000000);
      rst = 1'b1;
      tick();
      tick();
      got = outs();
      checks++;
      if (got !== 10'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected %b", got, 10'b0);
      end
      checks++;
      if (state_dbg !== 3'd0) begin
         errors++;
         $display("FAIL reset_state: got %0d expected 0", state_dbg);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic_rr();
      logic [5:0] st [13];
      logic [9:0] ev [13];
      logic [9:0] got, e;
      st = '{6'b110010, 6'b110010, 6'b111010, 6'b110010, 6'b110010, 6'b110011,
             6'b110010, 6'b110010, 6'b010110, 6'b010010, 6'b010010, 6'b010011,
             6'b000000};
      ev = '{10'b1001000100, 10'b1001000100, 10'b1001100100, 10'b1001101100,
             10'b1001101100, 10'b0000000100, 10'b0000000000, 10'b0110000100,
             10'b0110010100, 10'b0110010100, 10'b0110011100, 10'b0000000100,
             10'b0000000000};
      for (int i = 0; i < 13; i++) begin
         drive(st[i]);
         exp_q.push_back(ev[i]);
         tick();
         got = outs();
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL basic_rr cycle %0d: got %b expected %b", i, got, e);
         end
      end
   endtask

   task automatic test_addr_err();
      logic [5:0] st [5];
      logic [9:0] ev [5];
      logic [9:0] got, e;
      st = '{6'b010010, 6'b010110, 6'b010110, 6'b000010, 6'b000010};
      ev = '{10'b0110000100, 10'b0110010100, 10'b0000000110, 10'b0000000000,
             10'b0000000000};
      for (int i = 0; i < 5; i++) begin
         drive(st[i]);
         exp_q.push_back(ev[i]);
         tick();
         got = outs();
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL addr_err cycle %0d: got %b expected %b", i, got, e);
         end
      end
   endtask

   task automatic test_wait_timeout();
      logic [5:0] st [8];
      logic [9:0] ev [8];
      logic [9:0] got, e;
      st = '{6'b100000, 6'b101000, 6'b100000, 6'b100000, 6'b100000, 6'b100000,
             6'b100000, 6'b000000};
      ev = '{10'b1001000100, 10'b1001010100, 10'b1001010100, 10'b1001010100,
             10'b1001010100, 10'b1001010100, 10'b0000000101, 10'b0000000000};
      for (int i = 0; i < 8; i++) begin
         drive(st[i]);
         exp_q.push_back(ev[i]);
         tick();
         got = outs();
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL wait_timeout cycle %0d: got %b expected %b", i, got, e);
         end
      end
   endtask

   task automatic test_xfer_timeout();
      logic [5:0] st [18];
      logic [9:0] ev [18];
      logic [9:0] got, e;
      st = '{6'b100000, 6'b100000, 6'b100000, 6'b100010, 6'b100000, 6'b100000,
             6'b100000, 6'b100001, 6'b000000, 6'b100000, 6'b101001, 6'b100001,
             6'b100010, 6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b000000};
      ev = '{10'b1001000100, 10'b1001000100, 10'b1001000100, 10'b1001001100,
             10'b1001001100, 10'b1001001100, 10'b1001001100, 10'b0000000100,
             10'b0000000000, 10'b1001000100, 10'b1001010100, 10'b1001010100,
             10'b1001011100, 10'b1001011100, 10'b1001011100, 10'b1001011100,
             10'b0000000101, 10'b0000000000};
      for (int i = 0; i < 18; i++) begin
         drive(st[i]);
         exp_q.push_back(ev[i]);
         tick();
         got = outs();
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL xfer_timeout cycle %0d: got %b expected %b", i, got, e);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [5:0] st_a [4];
      logic [9:0] ev_a [4];
      logic [5:0] st_b [3];
      logic [9:0] ev_b [3];
      logic [9:0] got, e;
      st_a = '{6'b110000, 6'b110000, 6'b110000, 6'b110010};
      ev_a = '{10'b0110000100, 10'b0110000100, 10'b0110000100, 10'b0110001100};
      st_b = '{6'b110000, 6'b000000, 6'b000000};
      ev_b = '{10'b1001000100, 10'b0000000100, 10'b0000000000};
      for (int i = 0; i < 4; i++) begin
         drive(st_a[i]);
         exp_q.push_back(ev_a[i]);
         tick();
         got = outs();
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL reset_mid_pre cycle %0d: got %b expected %b", i, got, e);
         end
      end
      // Reset between edges: outputs must clear without waiting for a clock.
      #2 rst = 1'b1;
      #1;
      got = outs();
      checks++;
      if (got !== 10'b0) begin
         errors++;
         $display("FAIL reset_mid_async: got %b expected %b", got, 10'b0);
      end
      checks++;
      if (state_dbg !== 3'd0) begin
         errors++;
         $display("FAIL reset_mid_state: got %0d expected 0", state_dbg);
      end
      #2 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(st_b[i]);
         exp_q.push_back(ev_b[i]);
         tick();
         got = outs();
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL reset_mid_post cycle %0d: got %b expected %b", i, got, e);
         end
      end
   endtask

   task automatic test_drop_addr1();
      logic [5:0] st [7];
      logic [9:0] ev [7];
      logic [9:0] got, e;
      st = '{6'b100000, 6'b111000, 6'b010000, 6'b010000, 6'b010000, 6'b000000,
             6'b000000};
      ev = '{10'b1001000100, 10'b1001010100, 10'b0000000100, 10'b0000000000,
             10'b0110000100, 10'b0000000100, 10'b0000000000};
      for (int i = 0; i < 7; i++) begin
         drive(st[i]);
         exp_q.push_back(ev[i]);
         tick();
         got = outs();
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL drop_addr1 cycle %0d: got %b expected %b", i, got, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_rr();
      test_addr_err();
      test_wait_timeout();
      test_xfer_timeout();
      test_reset_mid();
      test_drop_addr1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 8'd200, meaning the maximum cycles allowed in the SLAVE_WAIT state and, separately, in the XFER state before a forced release.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the system reset: asynchronous, active-high.
REQ-004 The block SHALL have ports m1_request and m2_request, input, 1 each, the master bus requests, level, held for the whole transaction.
REQ-005 The block SHALL have ports m1_slave_sel and m2_slave_sel, input, 1 each, the serial slave address from each master, LSB first, 2 bits.
REQ-006 The block SHALL have port slave_ready, input, 1, meaning the addressed slave can accept a transfer.
REQ-007 The block SHALL have port trans_done, input, 1, a single-cycle pulse from the granted master ending its transfer.
REQ-008 The block SHALL have ports m1_grant and m2_grant, output, 1 each, the grants, one-hot or zero.
REQ-009 The block SHALL have port bus_grant, output, 2, the owner code: 0 none, 1 master1, 2 master2.
REQ-010 The block SHALL have port slave_sel, output, 2, the decoded slave index.
REQ-011 The block SHALL have port sel_valid, output, 1, meaning slave_sel is stable and the transfer is enabled.
REQ-012 The block SHALL have port arbiter_busy, output, 1, high in every state except IDLE.
REQ-013 The block SHALL have port addr_err, output, 1, a one-cycle pulse on address 2'b11.
REQ-014 The block SHALL have port timeout_err, output, 1, a one-cycle pulse on a timeout release.

Function
REQ-015 The block SHALL implement the states IDLE, ADDR0, ADDR1, SLAVE_WAIT, XFER and RELEASE.
REQ-016 All outputs SHALL be registered.
REQ-017 In IDLE with exactly one request high, the block SHALL grant that master at the next edge and go to ADDR0.
REQ-018 In IDLE with both requests high, the block SHALL grant the master not served last (round-robin).
REQ-019 The block SHALL update last_served on every grant; its reset value SHALL be master2, so master1 wins the first tie.
REQ-020 While granted, m1_grant/m2_grant and bus_grant SHALL stay constant until RELEASE.
REQ-021 A non-granted request SHALL be ignored until the block returns to IDLE; there SHALL be no preemption, including by master1.
REQ-022 In ADDR0, slave_sel[0] SHALL take the granted master's serial bit, and the state SHALL go to ADDR1.
REQ-023 In ADDR1, slave_sel[1] SHALL take the serial bit.
REQ-024 If the assembled address is 2'b11, ADDR1 SHALL go to RELEASE and pulse addr_err; otherwise it SHALL go to SLAVE_WAIT.
REQ-025 SLAVE_WAIT SHALL go to XFER on the first edge with slave_ready=1, and sel_valid SHALL assert on that same edge.
REQ-026 XFER SHALL go to RELEASE on trans_done=1 or when the granted master's request falls.
REQ-027 An 8-bit wait counter SHALL clear on entry to SLAVE_WAIT and to XFER, and increment each cycle in those states.
REQ-028 When the wait counter reaches TIMEOUT-1 without an exit condition, the block SHALL go to RELEASE and pulse timeout_err.
REQ-029 RELEASE SHALL last exactly 1 cycle and clear the grants, bus_grant, sel_valid and slave_sel to 0.
REQ-030 RELEASE SHALL always be followed by IDLE, so there is a minimum 1-cycle bus gap between owners.
REQ-031 If the granted request falls in ADDR0, ADDR1 or SLAVE_WAIT, the block SHALL go to RELEASE with no error pulse.
REQ-032 If trans_done and a timeout occur on the same edge, trans_done SHALL take priority and timeout_err SHALL not pulse.
REQ-033 trans_done outside XFER SHALL be ignored.
REQ-034 Latency from request to grant SHALL be 1 cycle; from grant to sel_valid it SHALL be at least 3 cycles.

Reset
REQ-035 On rst=1 at any time, including mid-transfer, all outputs SHALL go to 0 immediately, the state SHALL go to IDLE, the wait counter SHALL clear, and last_served SHALL be set to master2.
REQ-036 After rst falls, the first edge SHALL evaluate requests from IDLE.

Verification
REQ-037 The bench SHALL cover: both requests from reset, m1 serial bits 0 then 1, slave_ready=1 -> m1_grant=1 and bus_grant=1 at cycle 1, slave_sel=2, sel_valid=1 at cycle 3.
REQ-038 The bench SHALL cover: after REQ-037, trans_done with both still requesting -> RELEASE, IDLE, then m2_grant=1 and bus_grant=2 (round-robin).
REQ-039 The bench SHALL cover: m2 sends serial 1,1 -> addr_err pulse 1 cycle, grant dropped after RELEASE, sel_valid never 1.
REQ-040 The bench SHALL cover: TIMEOUT=4, slave_ready held 0 -> timeout_err after 4 SLAVE_WAIT cycles, bus freed.
REQ-041 The bench SHALL cover: rst pulsed during XFER -> all outputs 0 asynchronously, and the next tie is granted to m1.
REQ-042 The bench SHALL cover: m1 request drops in ADDR1 -> RELEASE, no error pulses, and a pending m2 is granted 2 cycles later.
